// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
// Mode encoding is carried per beat; comp_const gives the mode-10 rounding offset.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_COMP  = 2'b10,
    MODE_ORC   = 2'b11
  } mode_e;

  // Half of the weight of the lowest kept column; zero when nothing is truncated.
  function automatic longint unsigned comp_const(int unsigned trunc);
    return (trunc == 0) ? 64'd0 : (64'd1 << (trunc - 1));
  endfunction

endpackage

// File: rtl/approx_mul_pipe_pp_array.sv
// Combinational partial-product array: exact, truncated, compensated or OR-compressed
// low columns, selected per operation.
module approx_pp_array
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 7
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  mode_e              mode_i,
  output logic               sat_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [PW-1:0] LoMask = ~({PW{1'b1}} << TRUNC);
  localparam logic [PW:0]   Comp   = (PW + 1)'(comp_const(TRUNC));

  logic [PW-1:0] row;
  logic [PW-1:0] full;
  logic [PW-1:0] hi;
  logic [PW-1:0] lo;
  logic [PW:0]   sum;

  // Each shifted row holds one pp bit per column, so masking a row selects whole columns.
  always_comb begin
    row  = '0;
    full = '0;
    hi   = '0;
    lo   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row  = PW'(b_i & {WIDTH{a_i[i]}}) << i;
      full = full + row;
      hi   = hi + (row & ~LoMask);
      lo   = lo | (row & LoMask);
    end
    sum = {1'b0, hi} + Comp;

    sat_o  = 1'b0;
    prod_o = full;
    unique case (mode_i)
      MODE_EXACT: prod_o = full;
      MODE_TRUNC: prod_o = hi;
      MODE_COMP: begin
        if (sum[PW]) begin
          prod_o = '1;
          sat_o  = 1'b1;
        end else begin
          prod_o = sum[PW-1:0];
        end
      end
      MODE_ORC:   prod_o = hi | lo;
      default:    prod_o = full;
    endcase
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with per-beat approximation mode and valid/ready streaming.
// Stage 1 holds operands; the pp array sits between stages 1 and 2; later stages only delay.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned TRUNC  = 7,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_sat
);

  localparam int unsigned PW = 2 * WIDTH;

  if (TRUNC > 2 * WIDTH - 1 || STAGES < 2 || STAGES > 4) begin : g_param_err
    $error("approx_mul_pipe: illegal TRUNC or STAGES");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;
  logic [TAG_W-1:0]  tag_s  [STAGES];
  logic [PW-1:0]     prod_s [STAGES];
  logic [STAGES-1:0] sat_s;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mode_e            mode_q, mode_d;

  // A stage can load when empty or when its occupant leaves this cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s] = !vld[s] || rdy[s+1];
    end
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    if (rdy[0] && in_valid) begin
      a_d    = in_a;
      b_d    = in_b;
      mode_d = mode_e'(in_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_EXACT;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end

  approx_pp_array #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_pp (
    .a_i    (a_q),
    .b_i    (b_q),
    .mode_i (mode_q),
    .sat_o  (sat_s[0]),
    .prod_o (prod_s[0])
  );

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             vld_q, vld_d, up_vld;
    logic [TAG_W-1:0] tag_q, tag_d, up_tag;

    if (s == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_tag = in_tag;
    end else begin : g_body
      assign up_vld = vld[s-1];
      assign up_tag = tag_s[s-1];
    end

    always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      if (rdy[s]) begin
        vld_d = up_vld;
        if (up_vld) tag_d = up_tag;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        tag_q <= '0;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
    end

    assign vld[s]   = vld_q;
    assign tag_s[s] = tag_q;

    if (s > 0) begin : g_data
      logic [PW-1:0] prod_q, prod_d;
      logic          sat_q, sat_d;

      always_comb begin
        prod_d = prod_q;
        sat_d  = sat_q;
        if (rdy[s] && up_vld) begin
          prod_d = prod_s[s-1];
          sat_d  = sat_s[s-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q <= '0;
          sat_q  <= 1'b0;
        end else begin
          prod_q <= prod_d;
          sat_q  <= sat_d;
        end
      end

      assign prod_s[s] = prod_q;
      assign sat_s[s]  = sat_q;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign out_prod  = prod_s[STAGES-1];
  assign out_tag   = tag_s[STAGES-1];
  assign out_sat   = sat_s[STAGES-1];

endmodule
